// File: rtl/global_typs_pkg.sv
// Shared types and constants for the UDP transmit path.
//   tx_data_type        : one byte lane with valid/last qualifiers
//   udp_tx_header_type  : header latched from the UDP transmit port
//   udp_tx_type         : UDP transmit port (header + byte lane)
//   ipv4_tx_header_type : request header handed to the IPv4 layer
//   ipv4_tx_type        : IPv4 transmit port (header + byte lane)
//   tx_result_t         : transmit status reported by each layer
package global_typs_pkg;

    localparam int         LEN_W         = 16;
    localparam int         UDP_HDR_BYTES = 8;
    localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SENDING = 2'd1,
        SENT    = 2'd2,
        ERR     = 2'd3
    } tx_result_t;

    typedef struct packed {
        logic [7:0] data_out;
        logic       data_out_valid;
        logic       data_out_last;
    } tx_data_type;

    typedef struct packed {
        logic [31:0]      dst_ip_addr;
        logic [15:0]      dst_port;
        logic [15:0]      src_port;
        logic [LEN_W-1:0] data_length;
        logic [15:0]      checksum;
    } udp_tx_header_type;

    typedef struct packed {
        udp_tx_header_type hdr;
        tx_data_type       data;
    } udp_tx_type;

    typedef struct packed {
        logic [7:0]       protocol;
        logic [LEN_W-1:0] data_length;
        logic [31:0]      dst_ip_addr;
    } ipv4_tx_header_type;

    typedef struct packed {
        ipv4_tx_header_type hdr;
        tx_data_type        data;
    } ipv4_tx_type;

    // Wire order of the 8-byte UDP header, big-endian fields.
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [15:0] src,
                                            input logic [15:0] dst,
                                            input logic [15:0] len,
                                            input logic [15:0] csum);
        logic [7:0] b;
        case (idx)
            3'd0:    b = src[15:8];
            3'd1:    b = src[7:0];
            3'd2:    b = dst[15:8];
            3'd3:    b = dst[7:0];
            3'd4:    b = len[15:8];
            3'd5:    b = len[7:0];
            3'd6:    b = csum[15:8];
            default: b = csum[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_tx_framer_hdr_serializer.sv
// udp_hdr_serializer: walks the 8 UDP header bytes in wire order.
//   clk, reset          : clock, async active-high reset
//   i_load              : restart at byte 0 (new frame)
//   i_advance           : current byte was accepted downstream
//   i_src_port .. i_checksum : header fields (held stable by the parent)
//   o_byte              : header byte at the current index
//   o_last              : current byte is the 8th header byte
//   o_done              : all 8 bytes have been accepted
module udp_hdr_serializer
    import global_typs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [15:0] i_len,
    input  logic [15:0] i_checksum,
    output logic [7:0]  o_byte,
    output logic        o_last,
    output logic        o_done
);

    logic [2:0] r_idx;
    logic       r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else if (i_advance && !r_done) begin
            // Index stays on the final byte; done marks it consumed.
            if (r_idx == 3'(UDP_HDR_BYTES - 1)) begin
                r_done <= 1'b1;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    assign o_byte = hdr_byte(r_idx, i_src_port, i_dst_port, i_len, i_checksum);
    assign o_last = (r_idx == 3'(UDP_HDR_BYTES - 1));
    assign o_done = r_done;

endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: UDP transmit framer between the UDP port and the IPv4 layer.
// Latches the UDP header, requests an IPv4 frame (protocol UDP, length
// payload+8), emits the 8 header bytes, then passes payload through with
// zero latency while checking the payload length against the header.
//   clk, reset             : clock, async active-high reset
//   udp_tx_start, udp_txi  : frame start pulse, header and payload lane in
//   udp_tx_result          : IDLE/SENDING/SENT/ERR status
//   udp_tx_data_out_ready  : upstream payload byte accepted (with valid)
//   ip_tx_start, ip_tx     : IPv4 request pulse, header and byte lane out
//   ip_tx_result           : status from the IPv4 layer
//   ip_tx_data_out_ready   : IPv4 layer accepts the ip_tx byte
//   o_dbg_state            : current FSM state
// Handshake: a byte moves on a rising edge where valid and ready are both
// high; valid never waits on ready, and a presented byte is held until taken.
module udp_tx_framer
    import global_typs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        udp_tx_start,
    input  udp_tx_type  udp_txi,
    output tx_result_t  udp_tx_result,
    output logic        udp_tx_data_out_ready,
    output logic        ip_tx_start,
    output ipv4_tx_type ip_tx,
    input  tx_result_t  ip_tx_result,
    input  logic        ip_tx_data_out_ready,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PAY   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state, w_state_next;
    tx_result_t         r_result, w_result_next;
    logic [LEN_W-1:0]   r_cnt, w_cnt_next;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic               w_len_hit;
    logic               r_ip_start;
    logic [15:0]        r_src, r_dst, r_csum;
    logic [LEN_W-1:0]   r_len;
    ipv4_tx_header_type r_ip_hdr;
    logic               w_start_ok;
    logic               w_hdr_adv;
    logic [7:0]         w_ser_byte;
    logic               w_ser_last;
    logic               w_ser_done;
    tx_data_type        w_ip_data;
    logic               w_udp_ready;

    assign w_start_ok = (r_state == ST_IDLE) && udp_tx_start;
    // 1-based index of the payload byte currently on the lane.
    assign w_cnt_inc  = r_cnt + LEN_W'(1);
    assign w_len_hit  = (w_cnt_inc == r_len);

    udp_hdr_serializer u_hdr_ser (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_ok),
        .i_advance  (w_hdr_adv),
        .i_src_port (r_src),
        .i_dst_port (r_dst),
        .i_len      (r_ip_hdr.data_length),
        .i_checksum (r_csum),
        .o_byte     (w_ser_byte),
        .o_last     (w_ser_last),
        .o_done     (w_ser_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= IDLE;
            r_cnt      <= '0;
            r_ip_start <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_csum     <= '0;
            r_len      <= '0;
            r_ip_hdr   <= '0;
        end else begin
            r_result   <= w_result_next;
            r_cnt      <= w_cnt_next;
            r_ip_start <= w_start_ok;
            if (w_start_ok) begin
                r_src                <= udp_txi.hdr.src_port;
                r_dst                <= udp_txi.hdr.dst_port;
                r_csum               <= udp_txi.hdr.checksum;
                r_len                <= udp_txi.hdr.data_length;
                r_ip_hdr.protocol    <= IP_PROTO_UDP;
                r_ip_hdr.data_length <= udp_txi.hdr.data_length + LEN_W'(UDP_HDR_BYTES);
                r_ip_hdr.dst_ip_addr <= udp_txi.hdr.dst_ip_addr;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_cnt_next    = r_cnt;
        w_ip_data     = '0;
        w_udp_ready   = 1'b0;
        w_hdr_adv     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (udp_tx_start) begin
                    w_state_next  = ST_HDR;
                    w_result_next = SENDING;
                    w_cnt_next    = '0;
                end
            end

            ST_HDR: begin
                // The ip_tx_start cycle carries no data byte.
                w_ip_data.data_out       = w_ser_byte;
                w_ip_data.data_out_valid = !r_ip_start && !w_ser_done;
                w_ip_data.data_out_last  = w_ser_last && (r_len == '0);
                if (w_ip_data.data_out_valid && ip_tx_data_out_ready) begin
                    w_hdr_adv = 1'b1;
                    if (w_ser_last) begin
                        if (r_len == '0) begin
                            w_state_next  = ST_DONE;
                            w_result_next = SENT;
                        end else begin
                            w_state_next = ST_PAY;
                        end
                    end
                end
            end

            ST_PAY: begin
                w_ip_data.data_out       = udp_txi.data.data_out;
                w_ip_data.data_out_valid = udp_txi.data.data_out_valid;
                // Last is forced at the declared length and also forwarded
                // from a short upstream frame.
                w_ip_data.data_out_last  = udp_txi.data.data_out_valid &&
                                           (w_len_hit || udp_txi.data.data_out_last);
                w_udp_ready              = ip_tx_data_out_ready;
                if (udp_txi.data.data_out_valid && ip_tx_data_out_ready) begin
                    w_cnt_next = w_cnt_inc;
                    if (udp_txi.data.data_out_last) begin
                        w_state_next  = ST_DONE;
                        w_result_next = w_len_hit ? SENT : ERR;
                    end else if (w_len_hit) begin
                        w_state_next  = ST_DRAIN;
                        w_result_next = ERR;
                    end
                end
            end

            ST_DRAIN: begin
                w_udp_ready = 1'b1;
                if (udp_txi.data.data_out_valid && udp_txi.data.data_out_last) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // IPv4 layer failure aborts the frame. A zero-length frame has no
        // upstream payload to drain, so it finishes directly.
        if ((ip_tx_result == ERR) &&
            (r_state == ST_HDR || r_state == ST_PAY || r_state == ST_DRAIN)) begin
            w_result_next = ERR;
            if (r_len == '0) begin
                w_state_next = ST_DONE;
            end else if (w_state_next != ST_DONE) begin
                w_state_next = ST_DRAIN;
            end
        end
    end

    assign udp_tx_result         = r_result;
    assign udp_tx_data_out_ready = w_udp_ready;
    assign ip_tx_start           = r_ip_start;
    assign ip_tx.hdr             = r_ip_hdr;
    assign ip_tx.data            = w_ip_data;
    assign o_dbg_state           = r_state;

endmodule
